riscv_imem_pipe: RTL
====================

# riscv_imem_pipe

Parametrised, pipelined instruction memory for the RV32I core, replacing the single-cycle combinational-read array with a synchronous-read store. Reads use a valid/ready request/response handshake with configurable read latency, full-pipeline backpressure and a flush for fetch redirects. A byte-enabled write port allows program loading or self-test at run time. It sits between the fetch stage (PC generator) and the decode stage.

## Interface
- XLEN, 32: instruction/data word width in bits; must be a multiple of 8.
- IMEM_ADDR_BIT, 12: byte-address width; depth is 2**(IMEM_ADDR_BIT-2) words.
- RD_LAT, 2: read latency in cycles from request acceptance to response valid; legal range 1..4.

- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_req_valid  in  1  fetch request present.
- o_req_ready  out  1  request accepted this cycle when high together with i_req_valid.
- i_req_addr  in  IMEM_ADDR_BIT  byte address (PC).
- i_flush  in  1  discards all in-flight requests (branch/jump redirect).
- o_rsp_valid  out  1  response word valid.
- i_rsp_ready  in  1  decode consumes the response when high together with o_rsp_valid.
- o_rsp_data  out  XLEN  instruction word.
- o_rsp_addr  out  IMEM_ADDR_BIT  byte address of the returned word.
- o_rsp_misalign  out  1  request address had addr[1:0] != 0.
- i_wr_en  in  1  write strobe.
- i_wr_addr  in  IMEM_ADDR_BIT-2  word address for the write.
- i_wr_be  in  XLEN/8  byte enables; bit n writes data[8n+7:8n].
- i_wr_data  in  XLEN  write data.

## Operation
- Word index = i_req_addr[IMEM_ADDR_BIT-1:2]. addr[1:0] is ignored for the read, carried down the pipe, and reported on o_rsp_misalign.
- Pipeline: RD_LAT stages. Each stage holds {valid, addr, misalign}; the last stage also holds data. Stage 1 is the registered array read; stages 2..RD_LAT are plain data registers.
- Stall condition = o_rsp_valid && !i_rsp_ready.
  - On stall, every stage holds its contents, array read-enable is low, and o_req_ready=0.
  - No bubble squeezing: the whole pipe freezes.
- o_req_ready = !stall && !i_flush.
- Flush:
  - i_flush=1 clears all stage valid bits at the next edge, whatever the stall state.
  - A request presented in the flush cycle is not accepted (o_req_ready=0).
  - Data/addr registers may keep stale values; only the valid bits matter.
- Write port:
  - Independent of the handshake and never stalled.
  - Byte-masked write at the rising edge.
- Read/write collision (same word, same cycle): the read returns the old contents (read-first). A write to a word whose read is already in flight does not alter that response.
- Memory contents are not reset. Under `IMEM_INIT` the array is loaded with $readmemh from the file named by plusarg text_mif.

## Timing
- Reset (i_rstn=0, asynchronous): all stage valid bits=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_addr=0, o_rsp_misalign=0. o_req_ready follows its equation (1 when i_flush=0).
- Reset deasserted mid-stream: in-flight requests are lost and no responses appear for them.
- Request accepted at edge T → o_rsp_valid=1 after edge T+RD_LAT-1, i.e. visible RD_LAT cycles after the request is presented, when no stall occurs.
- Each stall cycle adds exactly one cycle of latency to every in-flight request.
- Throughput: one request per cycle with i_rsp_ready held high.
- Responses are in request order, with no loss or duplication except by flush or reset.
- o_rsp_* are stable while o_rsp_valid=1 and i_rsp_ready=0.
- Flush and i_rsp_ready in the same cycle: the current response counts as consumed, and o_rsp_valid=0 the next cycle.

## Test plan
- Streaming read, RD_LAT=2: preload word 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193; requests at addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles with i_rsp_ready=1 → the four words return in order on four consecutive cycles, first valid 2 cycles after the first request, with o_rsp_addr matching each request.
- Backpressure: same stream, i_rsp_ready=0 for 3 cycles while the first response is valid → o_req_ready=0 and o_rsp_data held at 0x00000013 for those cycles; after release, all four words arrive with no loss or duplication.
- Flush: 2 requests in flight, then i_flush=1 together with a request to 0x10 → no response for any of the three; a request to 0x20 in the next cycle returns word 8 after RD_LAT cycles.
- Byte-enable write and collision:
  - Word 5 = 0xAABBCCDD; write 0x11223344 with be=4'b0101 → word 5 reads 0xAA22CC44.
  - A read of word 5 in the same cycle as the write returns the old value.
- Misalign and reset:
  - Request to 0x6 → word 1 returned with o_rsp_misalign=1.
  - Assert i_rstn=0 with requests in flight → o_rsp_valid=0 immediately, and after release no stale responses appear.
- Parameter sweep: repeat the streaming test with RD_LAT=1 and RD_LAT=4, and with IMEM_ADDR_BIT=10 → latency equals RD_LAT, and the top word (index 255) is readable.

Source files
------------

// File: rtl/riscv_imem_pipe.sv
// Synchronous-read instruction memory with a RD_LAT-deep valid/ready read pipe and a byte-masked write port.
// Latency RD_LAT cycles from acceptance; a stalled response freezes the whole pipe and drops o_req_ready.
module riscv_imem_pipe #(
   parameter int XLEN          = 32,
   parameter int IMEM_ADDR_BIT = 12,
   parameter int RD_LAT        = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic [IMEM_ADDR_BIT-1:0] i_req_addr,
   input  logic                     i_flush,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [XLEN-1:0]          o_rsp_data,
   output logic [IMEM_ADDR_BIT-1:0] o_rsp_addr,
   output logic                     o_rsp_misalign,
   input  logic                     i_wr_en,
   input  logic [IMEM_ADDR_BIT-3:0] i_wr_addr,
   input  logic [XLEN/8-1:0]        i_wr_be,
   input  logic [XLEN-1:0]          i_wr_data
);

   localparam int DEPTH = 2 ** (IMEM_ADDR_BIT - 2);
   localparam int NBYTE = XLEN / 8;

   typedef struct packed {
      logic [IMEM_ADDR_BIT-1:0] addr;
      logic                     misalign;
   } meta_t;

   logic [XLEN-1:0]   mem  [DEPTH];
   logic [RD_LAT-1:0] vld;
   meta_t             meta [RD_LAT];
   logic [XLEN-1:0]   dat  [RD_LAT];
   logic              stall;
   logic              accept;

   assign stall       = vld[RD_LAT-1] && !i_rsp_ready;
   assign o_req_ready = !stall && !i_flush;
   assign accept      = i_req_valid && o_req_ready;

   assign o_rsp_valid    = vld[RD_LAT-1];
   assign o_rsp_data     = dat[RD_LAT-1];
   assign o_rsp_addr     = meta[RD_LAT-1].addr;
   assign o_rsp_misalign = meta[RD_LAT-1].misalign;

   // Array contents are deliberately not reset; the write port never stalls.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         for (int b = 0; b < NBYTE; b++) begin
            if (i_wr_be[b]) mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
         end
      end
   end

   // Stage 0 samples the array in the same edge as any write, so a colliding read sees old data.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         vld <= '0;
         for (int k = 0; k < RD_LAT; k++) begin
            meta[k] <= '0;
            dat[k]  <= '0;
         end
      end else begin
         if (i_flush) begin
            vld <= '0;
         end else if (!stall) begin
            vld[0] <= accept;
            for (int k = 1; k < RD_LAT; k++) vld[k] <= vld[k-1];
         end
         if (!stall) begin
            meta[0] <= '{addr: i_req_addr, misalign: |i_req_addr[1:0]};
            if (accept) dat[0] <= mem[i_req_addr[IMEM_ADDR_BIT-1:2]];
            for (int k = 1; k < RD_LAT; k++) begin
               meta[k] <= meta[k-1];
               dat[k]  <= dat[k-1];
            end
         end
      end
   end

endmodule
